// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared state type, frame-count type and timing helpers for
//               the WS2801 frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    typedef logic [15:0] frame_cnt_t;

    function automatic int frame_cyc(input longint freq, input longint hz);
        return int'(freq / hz);
    endfunction

    // Rounded up so the latch gap never falls short of the requested time.
    function automatic int latch_cyc(input longint freq, input longint us);
        return int'((freq * us + 999_999) / 1_000_000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running counter over 0..PERIOD-1; tick is high for the
//               single cycle in which the counter wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_scheduler
// Description : Paces frames to a WS2801 driver at FRAME_HZ with a one-deep
//               pending buffer, latch gap, SEND timeout and sticky errors.
//               Optional macro LED_SCHED_REPEAT_EN re-sends the active frame
//               on ticks that find no pending frame.
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int LEDS     = 50,
    parameter int FREQ     = 781250,
    parameter int FRAME_HZ = 60,
    parameter int LATCH_US = 500,
    parameter int TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [24*LEDS-1:0]   frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [24*LEDS-1:0]   drv_rgb,
    output logic                 drv_start,
    input  logic                 drv_done,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [1:0]           err
);

    localparam int            FRAME_CYC  = frame_cyc(FREQ, FRAME_HZ);
    localparam int            LATCH_CYC  = latch_cyc(FREQ, LATCH_US);
    localparam int            CNT_MAX    = (TIMEOUT > LATCH_CYC) ? TIMEOUT : LATCH_CYC;
    localparam int            CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SEND_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam int            W          = 24 * LEDS;

    state_e        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  pend_q,   pend_d;
    logic          pend_v_q, pend_v_d;
    logic [W-1:0]  rgb_q,    rgb_d;
    frame_cnt_t    fcnt_q,   fcnt_d;
    logic [1:0]    err_q,    err_d;
    logic          w_tick;

    led_tick_gen #(
        .PERIOD (FRAME_CYC)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        rgb_d    = rgb_q;
        fcnt_d   = fcnt_q;
        err_d    = err_q;

        // A tick that finds us busy is dropped, not deferred.
        if (w_tick && (state_q != ST_IDLE)) begin
            err_d[0] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    if (pend_v_q) begin
                        rgb_d    = pend_q;
                        pend_v_d = 1'b0;
                        state_d  = ST_START;
                    end
`ifdef LED_SCHED_REPEAT_EN
                    else begin
                        state_d = ST_START;
                    end
`endif
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (drv_done) begin
                    fcnt_d  = fcnt_q + 16'd1;
                    cnt_d   = '0;
                    state_d = ST_LATCH;
                end else if (cnt_q == SEND_LAST) begin
                    err_d[1] = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading requires pend_v, accepting requires !pend_v: never both.
        if (frame_valid && !pend_v_q) begin
            pend_d   = frame_in;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            rgb_q    <= '0;
            fcnt_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            rgb_q    <= rgb_d;
            fcnt_q   <= fcnt_d;
            err_q    <= err_d;
        end
    end

    assign frame_ready = ~pend_v_q;
    assign drv_start   = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign drv_rgb     = rgb_q;
    assign frame_cnt   = fcnt_q;
    assign err         = err_q;

endmodule
`default_nettype wire
